// File: rtl/uart_rx_cfg_if.sv
// Receive stream from the UART receiver: one frame per beat plus its error flags.
`timescale 1ns/1ps
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_perr;
    logic                 m_ferr;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, m_perr, m_ferr, m_valid, input m_ready);
    modport slave  (input m_data, m_perr, m_ferr, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, oversampled majority vote, frame FSM
// and a small output FIFO with overrun reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s = 0 on a tick
// S_START  | qualifying the start bit; a high vote aborts as a glitch
// S_DATA   | shifting in DATA_BITS data bits, LSB first
// S_PARITY | checking the parity bit (only when PARITY != 0)
// S_STOP   | sampling STOP_BITS stop bits; frame pushed at last decision
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    uart_rx_cfg_if.master m,
    output logic          overrun,
    output logic          busy
);
    localparam int DIV   = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = DATA_BITS + 2;

    localparam logic [TW-1:0] T_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_M    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_chk_div
        $error("uart_rx_cfg: CLK_FREQ_HZ too low for BAUD_RATE * OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
        $error("uart_rx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 rx_m, rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] data, data_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic [1:0]           samp, samp_n;
    logic                 vote;
    logic                 push;
    logic [EW-1:0]        push_word;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, pop, push_ok;
    logic [EW-1:0]        head;

    // Two-flop synchroniser; flops idle high like the line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == '0) begin
            div_cnt <= DIV_W'(DIV - 1);
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tick = (div_cnt == '0);
    assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            samp     <= 2'b11;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            data     <= data_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
            samp     <= samp_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        data_n     = data;
        perr_n     = perr;
        ferr_n     = ferr;
        samp_n     = samp;
        push       = 1'b0;
        if (tick) begin
            tick_cnt_n = (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == T_A) samp_n[0] = rx_s;
            if (tick_cnt == T_B) samp_n[1] = rx_s;
            unique case (state)
                S_IDLE: begin
                    tick_cnt_n = '0;
                    if (!rx_s) begin
                        state_n = S_START;
                        data_n  = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_cnt == T_M && vote) begin
                        state_n    = S_IDLE;
                        tick_cnt_n = '0;
                    end else if (tick_cnt == T_LAST) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == T_M) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_cnt == BW'(i)) data_n[i] = vote;
                        end
                    end
                    if (tick_cnt == T_LAST) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_cnt == T_M) perr_n = ((^data) ^ vote) != (PARITY == 2);
                    if (tick_cnt == T_LAST) begin
                        state_n   = S_STOP;
                        bit_cnt_n = '0;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == T_M) begin
                        ferr_n = ferr | ~vote;
                        // Leave at the decision tick so the next start edge is caught early
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            push       = 1'b1;
                            state_n    = S_IDLE;
                            tick_cnt_n = '0;
                        end
                    end else if (tick_cnt == T_LAST) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign push_word = {perr_n, ferr_n, data_n};
    assign busy      = (state != S_IDLE);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && m.m_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            overrun <= push && !push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign m.m_valid = !empty;
    assign m.m_data  = empty ? '0 : head[DATA_BITS-1:0];
    assign m.m_ferr  = !empty && head[DATA_BITS];
    assign m.m_perr  = (PARITY != 0) && !empty && head[EW-1];
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: one default-rate 8N1 instance plus fast 8N1, 7E1 and 8N2
// instances; frames are scored against a queue of expected results.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int DIV_A  = 65;
    localparam int BIT_A  = DIV_A * 16;
    localparam int FAST_F = 614_400;
    localparam int BIT_F  = 4 * 16;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;
        logic [8:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line [4];
    logic       rdy [4];
    logic [8:0] md [4];
    logic       mv [4];
    logic       mp [4];
    logic       mf [4];
    logic       ovr [4];
    logic       bsy [4];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pop_cnt [4]   = '{default: 0};
    int   ov_cnt [4]    = '{default: 0};
    int   rise_cyc [4]  = '{default: 0};
    int   last_pop [4]  = '{default: 0};
    int   start_cyc [4] = '{default: 0};
    logic mv_q [4]      = '{default: 1'b0};
    logic busy_seen [4] = '{default: 1'b0};
    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [12];

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();
    uart_rx_cfg_if #(.DATA_BITS(7)) ifc ();
    uart_rx_cfg_if #(.DATA_BITS(8)) ifd ();

    uart_rx_cfg dut_a (.clk(clk), .rst(rst), .rx_i(rx_line[0]), .m(ifa), .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_cfg #(.CLK_FREQ_HZ(FAST_F)) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_line[1]), .m(ifb), .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_cfg #(.CLK_FREQ_HZ(FAST_F), .DATA_BITS(7), .PARITY(1)) dut_c (
        .clk(clk), .rst(rst), .rx_i(rx_line[2]), .m(ifc), .overrun(ovr[2]), .busy(bsy[2]));
    uart_rx_cfg #(.CLK_FREQ_HZ(FAST_F), .STOP_BITS(2)) dut_d (
        .clk(clk), .rst(rst), .rx_i(rx_line[3]), .m(ifd), .overrun(ovr[3]), .busy(bsy[3]));

    assign ifa.m_ready = rdy[0];
    assign ifb.m_ready = rdy[1];
    assign ifc.m_ready = rdy[2];
    assign ifd.m_ready = rdy[3];
    assign md[0] = {1'b0, ifa.m_data};
    assign md[1] = {1'b0, ifb.m_data};
    assign md[2] = {2'b00, ifc.m_data};
    assign md[3] = {1'b0, ifd.m_data};
    assign mv[0] = ifa.m_valid;  assign mp[0] = ifa.m_perr;  assign mf[0] = ifa.m_ferr;
    assign mv[1] = ifb.m_valid;  assign mp[1] = ifb.m_perr;  assign mf[1] = ifb.m_ferr;
    assign mv[2] = ifc.m_valid;  assign mp[2] = ifc.m_perr;  assign mf[2] = ifc.m_ferr;
    assign mv[3] = ifd.m_valid;  assign mp[3] = ifd.m_perr;  assign mf[3] = ifd.m_ferr;

    // Scoreboard: every accepted beat must match the oldest expected frame
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (ovr[d]) ov_cnt[d]++;
            if (bsy[d]) busy_seen[d] = 1'b1;
            if (mv[d] && !mv_q[d]) rise_cyc[d] = cyc;
            mv_q[d] = mv[d];
            if (mv[d] && rdy[d]) begin
                pop_cnt[d]++;
                last_pop[d] = cyc;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_frame dut%0d: got data=%h, expected no frame", d, md[d]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.dut != d || mon_e.data != md[d] || mon_e.perr != mp[d] || mon_e.ferr != mf[d]) begin
                        n_bad++;
                        $display("FAIL frame dut%0d: got data=%h perr=%b ferr=%b, expected dut%0d data=%h perr=%b ferr=%b",
                                 d, md[d], mp[d], mf[d], mon_e.dut, mon_e.data, mon_e.perr, mon_e.ferr);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_bit(input int d, input logic v, input int n);
        rx_line[d] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int d, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.dut  = d;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        sb.push_back(e);
    endtask

    // glitch_bit >= 0 drops one tick-wide low pulse in the middle of that data bit
    task automatic send_frame(input int d, input logic [8:0] data, input logic par,
                              input logic [1:0] stops, input int glitch_bit);
        int bc;
        int nb;
        int ns;
        bc = (d == 0) ? BIT_A : BIT_F;
        nb = (d == 2) ? 7 : 8;
        ns = (d == 3) ? 2 : 1;
        start_cyc[d] = cyc;
        drive_bit(d, 1'b0, bc);
        for (int i = 0; i < nb; i++) begin
            if (i == glitch_bit) begin
                drive_bit(d, data[i], bc / 2 - 2);
                drive_bit(d, 1'b0, bc / 16);
                drive_bit(d, data[i], bc - bc / 2 + 2 - bc / 16);
            end else begin
                drive_bit(d, data[i], bc);
            end
        end
        if (d == 2) drive_bit(d, par, bc);
        for (int i = 0; i < ns; i++) drive_bit(d, stops[i], bc);
        drive_bit(d, 1'b1, 2 * bc);
    endtask

    initial begin
        int lat;
        int rc;
        int p0;
        int exp_pops [4];

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            rx_line[d] = 1'b1;
            rdy[d]     = 1'b1;
        end
        vecs[0]  = '{1, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{1, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[2]  = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vecs[3]  = '{1, 9'h05A, 1'b0, 2'b10, 9'h05A, 1'b0, 1'b1};
        vecs[4]  = '{2, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
        vecs[5]  = '{2, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
        vecs[6]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        vecs[7]  = '{2, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b1, 1'b0};
        vecs[8]  = '{3, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
        vecs[9]  = '{3, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
        vecs[10] = '{3, 9'h0C3, 1'b0, 2'b10, 9'h0C3, 1'b0, 1'b1};
        vecs[11] = '{2, 9'h02A, 1'b1, 2'b10, 9'h02A, 1'b0, 1'b1};

        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_valid_%0d", d), int'(mv[d]), 0);
            check($sformatf("rst_data_%0d", d), int'(md[d]), 0);
            check($sformatf("rst_overrun_%0d", d), int'(ovr[d]), 0);
            check($sformatf("rst_busy_%0d", d), int'(bsy[d]), 0);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Default-rate 8N1 frame and its delivery latency
        expect_frame(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
        check("a5_pops", pop_cnt[0], 1);
        lat = rise_cyc[0] - start_cyc[0];
        n_cmp++;
        if (lat < 152 * DIV_A || lat > 156 * DIV_A) begin
            n_bad++;
            $display("FAIL a5_latency: got %0d clk, expected %0d..%0d clk", lat, 152 * DIV_A, 156 * DIV_A);
        end

        // Short low pulse: start qualified, then rejected by the vote
        busy_seen[0] = 1'b0;
        drive_bit(0, 1'b0, 195);
        drive_bit(0, 1'b1, BIT_A - 195);
        check("short_low_busy_seen", int'(busy_seen[0]), 1);
        check("short_low_busy_cleared", int'(bsy[0]), 0);
        drive_bit(0, 1'b1, 2 * BIT_A);
        check("short_low_no_frame", pop_cnt[0], 1);

        // Single-tick glitch inside bit 3 is outvoted
        expect_frame(1, 9'h0FF, 1'b0, 1'b0);
        send_frame(1, 9'h0FF, 1'b0, 2'b11, 3);

        foreach (vecs[i]) begin
            expect_frame(vecs[i].dut, vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr);
            send_frame(vecs[i].dut, vecs[i].data, vecs[i].par, vecs[i].stops, -1);
        end

        // Overrun: four frames fill the FIFO, the fifth is dropped
        rdy[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_frame(1, 9'(i), 1'b0, 1'b0);
            send_frame(1, 9'(i), 1'b0, 2'b11, -1);
        end
        check("ovr_none_before_5", ov_cnt[1], 0);
        check("ovr_head_held", int'(md[1]), 1);
        check("ovr_valid_held", int'(mv[1]), 1);
        send_frame(1, 9'h005, 1'b0, 2'b11, -1);
        check("ovr_pulse_count", ov_cnt[1], 1);
        @(posedge clk);
        #1;
        rc = cyc;
        p0 = pop_cnt[1];
        rdy[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("ovr_drain_pops", pop_cnt[1] - p0, 4);
        check("ovr_drain_back_to_back", last_pop[1] - rc, 3);
        check("ovr_drain_empty", int'(mv[1]), 0);

        // Reset in the middle of 0x11 discards it
        drive_bit(1, 1'b0, BIT_F);
        drive_bit(1, 1'b1, BIT_F);
        drive_bit(1, 1'b0, BIT_F);
        drive_bit(1, 1'b0, BIT_F / 2);
        check("mid_frame_busy", int'(bsy[1]), 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_line[1] = 1'b1;
        rst = 1'b0;
        check("post_rst_busy", int'(bsy[1]), 0);
        check("post_rst_valid", int'(mv[1]), 0);
        drive_bit(1, 1'b1, 2 * BIT_F);
        expect_frame(1, 9'h03C, 1'b0, 1'b0);
        send_frame(1, 9'h03C, 1'b0, 2'b11, -1);
        check("post_rst_overrun", ov_cnt[1], 1);

        exp_pops = '{1, 1 + 4 + 1, 0, 0};
        foreach (vecs[i]) exp_pops[vecs[i].dut]++;
        for (int d = 0; d < 4; d++) check($sformatf("pop_count_%0d", d), pop_cnt[d], exp_pops[d]);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
